// File: rtl/trace_window_ctrl.sv
// trace_window_ctrl
//   Generates the enable for the JSONL trace logger so that only a chosen
//   slice of execution is dumped. When armed, the block opens a capture window
//   when a WB-stage retirement matches cfg_start_pc. The window closes on a
//   stop-PC retirement, when the traced-cycle budget runs out, or on abort.
//
//   Optional feature macro: TRACE_WINDOW_DECIM_EN
//     When defined, only 1 of every cfg_decim+1 CAPTURE cycles is traced, and
//     the budget counts traced cycles only. When undefined, cfg_decim is
//     ignored and every CAPTURE cycle is traced.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   arm, abort          single-cycle control pulses
//   cfg_*               window configuration; sampled live, not latched
//   commit_valid/pc     WB-stage retirement
//   trace_en            registered enable to the trace logger
//   state               IDLE=0 ARMED=1 CAPTURE=2 DONE=3
//   captured_cycles     cycles with trace_en=1 since the last arm (saturating)
//   done                high while in DONE
module trace_window_ctrl #(
    parameter int CNT_W   = 32,
    parameter int DECIM_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               abort,
    input  logic [31:0]        cfg_start_pc,
    input  logic [31:0]        cfg_stop_pc,
    input  logic               cfg_use_stop_pc,
    input  logic [CNT_W-1:0]   cfg_max_cycles,
    input  logic [DECIM_W-1:0] cfg_decim,
    input  logic               commit_valid,
    input  logic [31:0]        commit_pc,
    output logic               trace_en,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   captured_cycles,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t st;

    logic start_hit, stop_hit, budget_hit;

    assign start_hit = commit_valid && (commit_pc == cfg_start_pc);
    assign stop_hit  = cfg_use_stop_pc && commit_valid && (commit_pc == cfg_stop_pc);
    // The current traced cycle is the last one the budget allows. A saturated
    // counter wraps to 0 here, which can never equal a non-zero budget.
    assign budget_hit = trace_en && (cfg_max_cycles != '0) &&
                        ((captured_cycles + CNT_W'(1)) == cfg_max_cycles);

`ifdef TRACE_WINDOW_DECIM_EN
    logic [DECIM_W-1:0] phase;
    logic [DECIM_W-1:0] phase_nxt;
    assign phase_nxt = (phase == cfg_decim) ? '0 : phase + DECIM_W'(1);
`else
    logic unused_decim;
    assign unused_decim = ^cfg_decim;
`endif

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st              <= IDLE;
            trace_en        <= 1'b0;
            captured_cycles <= '0;
            done            <= 1'b0;
`ifdef TRACE_WINDOW_DECIM_EN
            phase           <= '0;
`endif
        end else begin
            // Count this cycle if it was traced; arm below overrides with a
            // clear, but trace_en is never 1 in the states that accept arm.
            if (trace_en && (captured_cycles != '1))
                captured_cycles <= captured_cycles + CNT_W'(1);

            if (abort) begin
                st       <= IDLE;
                trace_en <= 1'b0;
                done     <= 1'b0;
`ifdef TRACE_WINDOW_DECIM_EN
                phase    <= '0;
`endif
            end else begin
                case (st)
                    IDLE: begin
                        if (arm) begin
                            st              <= ARMED;
                            captured_cycles <= '0;
                        end
                    end
                    ARMED: begin
                        // Stop PC is deliberately not checked before the window opens.
                        if (start_hit) begin
                            st       <= CAPTURE;
                            trace_en <= 1'b1;
`ifdef TRACE_WINDOW_DECIM_EN
                            phase    <= '0;
`endif
                        end
                    end
                    CAPTURE: begin
                        if (stop_hit || budget_hit) begin
                            st       <= DONE;
                            trace_en <= 1'b0;
                            done     <= 1'b1;
                        end else begin
`ifdef TRACE_WINDOW_DECIM_EN
                            phase    <= phase_nxt;
                            trace_en <= (phase_nxt == '0);
`else
                            trace_en <= 1'b1;
`endif
                        end
                    end
                    DONE: begin
                        if (arm) begin
                            st              <= ARMED;
                            done            <= 1'b0;
                            captured_cycles <= '0;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trace_window_ctrl.sv
module tb_trace_window_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm, abort;
    logic [31:0] cfg_start_pc, cfg_stop_pc;
    logic        cfg_use_stop_pc;
    logic [31:0] cfg_max_cycles;
    logic [7:0]  cfg_decim;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        trace_en;
    logic [1:0]  state;
    logic [31:0] captured_cycles;
    logic        done;

    // Narrow-counter instance for the saturation case.
    logic        b_arm, b_commit_valid;
    logic [31:0] b_commit_pc;
    logic        b_trace_en;
    logic [1:0]  b_state;
    logic [3:0]  b_captured;
    logic        b_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_window_ctrl #(.CNT_W(32), .DECIM_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .cfg_start_pc(cfg_start_pc), .cfg_stop_pc(cfg_stop_pc),
        .cfg_use_stop_pc(cfg_use_stop_pc), .cfg_max_cycles(cfg_max_cycles),
        .cfg_decim(cfg_decim), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .trace_en(trace_en), .state(state), .captured_cycles(captured_cycles),
        .done(done)
    );

    trace_window_ctrl #(.CNT_W(4), .DECIM_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .arm(b_arm), .abort(1'b0),
        .cfg_start_pc(32'h100), .cfg_stop_pc(32'h0),
        .cfg_use_stop_pc(1'b0), .cfg_max_cycles(4'd0),
        .cfg_decim(8'd0), .commit_valid(b_commit_valid), .commit_pc(b_commit_pc),
        .trace_en(b_trace_en), .state(b_state), .captured_cycles(b_captured),
        .done(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic te,
                           input logic [31:0] cnt, input logic dn);
        chk({tag, ".state"}, 64'(state), 64'(st));
        chk({tag, ".trace_en"}, 64'(trace_en), 64'(te));
        chk({tag, ".captured"}, 64'(captured_cycles), 64'(cnt));
        chk({tag, ".done"}, 64'(done), 64'(dn));
    endtask

    initial begin
        logic [7:0] te_exp, done_exp;

        rst_n = 1'b0; arm = 0; abort = 0;
        cfg_start_pc = 32'h100; cfg_stop_pc = 32'h120; cfg_use_stop_pc = 0;
        cfg_max_cycles = 4; cfg_decim = 0; commit_valid = 0; commit_pc = 0;
        b_arm = 0; b_commit_valid = 0; b_commit_pc = 0;
        step(); step();
        chk_all("reset", 2'd0, 1'b0, 32'd0, 1'b0);
        rst_n = 1'b1;
        step();

        // Budget window: max=4 -> four traced cycles then DONE.
        arm = 1; step(); arm = 0;
        chk_all("arm", 2'd1, 1'b0, 32'd0, 1'b0);
        commit_valid = 1; commit_pc = 32'h104; step();
        chk("nonmatch.state", 64'(state), 64'd1);
        commit_pc = 32'h100; step(); commit_valid = 0;
        chk_all("budget.c11", 2'd2, 1'b1, 32'd0, 1'b0);
        step(); step(); step();
        chk_all("budget.c14", 2'd2, 1'b1, 32'd3, 1'b0);
        step();
        chk_all("budget.c15", 2'd3, 1'b0, 32'd4, 1'b1);
        step();
        chk_all("budget.hold", 2'd3, 1'b0, 32'd4, 1'b1);

        // Re-arm from DONE, then stop-PC window.
        cfg_max_cycles = 0; cfg_use_stop_pc = 1;
        arm = 1; step(); arm = 0;
        chk_all("rearm", 2'd1, 1'b0, 32'd0, 1'b0);
        commit_valid = 1; commit_pc = 32'h120; step();
        chk("stop_in_armed.state", 64'(state), 64'd1);
        commit_pc = 32'h100; step(); commit_valid = 0;
        chk_all("stop.c11", 2'd2, 1'b1, 32'd0, 1'b0);
        arm = 1; step(); arm = 0;
        chk_all("arm_in_capture", 2'd2, 1'b1, 32'd1, 1'b0);
        for (int i = 13; i <= 20; i++) begin
            step();
            chk("stop.window_te", 64'(trace_en), 64'd1);
        end
        chk("stop.c20_cnt", 64'(captured_cycles), 64'd9);
        commit_valid = 1; commit_pc = 32'h120; step(); commit_valid = 0;
        chk_all("stop.c21", 2'd3, 1'b0, 32'd10, 1'b1);

        // Abort mid-capture: count holds at the traced cycles incl. abort cycle.
        cfg_use_stop_pc = 0;
        arm = 1; step(); arm = 0;
        commit_valid = 1; commit_pc = 32'h100; step(); commit_valid = 0;
        chk_all("abort.open", 2'd2, 1'b1, 32'd0, 1'b0);
        step();
        abort = 1; step(); abort = 0;
        chk_all("abort.idle", 2'd0, 1'b0, 32'd2, 1'b0);
        step();
        chk_all("abort.hold", 2'd0, 1'b0, 32'd2, 1'b0);
        arm = 1; step(); arm = 0;
        chk_all("arm_from_idle", 2'd1, 1'b0, 32'd0, 1'b0);

        // Start match and abort in the same cycle -> IDLE.
        commit_valid = 1; commit_pc = 32'h100; abort = 1; step();
        commit_valid = 0; abort = 0;
        chk_all("start_abort", 2'd0, 1'b0, 32'd0, 1'b0);

        // Decimation: decim=2, max=3; k=0 is the first capture cycle.
        cfg_decim = 2; cfg_max_cycles = 3;
        arm = 1; step(); arm = 0;
        commit_valid = 1; commit_pc = 32'h100; step(); commit_valid = 0;
`ifdef TRACE_WINDOW_DECIM_EN
        te_exp = 8'b0100_1001; done_exp = 8'b1000_0000;
`else
        te_exp = 8'b0000_0111; done_exp = 8'b1111_1000;
`endif
        for (int k = 0; k < 8; k++) begin
            chk("decim.trace_en", 64'(trace_en), 64'(te_exp[k]));
            chk("decim.done", 64'(done), 64'(done_exp[k]));
            step();
        end
        chk("decim.captured", 64'(captured_cycles), 64'd3);
        cfg_decim = 0;

        // Saturation on the 4-bit counter instance.
        b_arm = 1; step(); b_arm = 0;
        b_commit_valid = 1; b_commit_pc = 32'h100; step(); b_commit_valid = 0;
        chk("sat.open", 64'(b_state), 64'd2);
        for (int i = 0; i < 15; i++) step();
        chk("sat.at15", 64'(b_captured), 64'd15);
        for (int i = 0; i < 5; i++) step();
        chk("sat.stick", 64'(b_captured), 64'd15);
        chk("sat.state", 64'(b_state), 64'd2);
        chk("sat.te", 64'(b_trace_en), 64'd1);

        // Asynchronous reset mid-capture: outputs drop without a clock edge.
        cfg_max_cycles = 0;
        arm = 1; step(); arm = 0;
        commit_valid = 1; commit_pc = 32'h100; step(); commit_valid = 0;
        step();
        chk_all("pre_reset", 2'd2, 1'b1, 32'd1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_all("async_reset", 2'd0, 1'b0, 32'd0, 1'b0);
        chk("async_reset.b_te", 64'(b_trace_en), 64'd0);
        chk("async_reset.b_cnt", 64'(b_captured), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
